// File: rtl/seg7_scan.sv
// seg7_scan -- four-digit multiplexed seven-segment display driver.
//
// Captures four hex digits and their decimal points into a shadow register
// on a load strobe. Scans the digits round-robin with a programmable dwell
// time per digit. Each slot starts with a dead time in which all anodes are
// off, so the previous digit does not ghost onto the next one.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 2)
//   DEAD_CYC  cycles at the start of each slot with all anodes off (< SCAN_DIV)
//
// Ports:
//   clk     in   single clock, rising edge
//   rst     in   synchronous active-low reset
//   en      in   scan enable; low freezes the scan and blanks the anodes
//   load    in   one-cycle strobe that captures digits/dp into the shadow
//   digits  in   [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
//   dp      in   decimal point request, bit i = digit i
//   an      out  active-low anode select, bit i = digit i
//   seg     out  active-low segments {g,f,e,d,c,b,a}
//   dp_n    out  active-low decimal point
//   frame   out  one-cycle pulse when digit 0 first appears after a wrap
//
// Optional feature: define SEG7_LZ_BLANK_EN to enable leading-zero blanking
// of digits 3..1. Digit 0 is never blanked.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame
);

    localparam int unsigned   PW      = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_LIT = PW'(DEAD_CYC);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shd_dig_q, shd_dig_d;
    logic [3:0]    shd_dp_q, shd_dp_d;
    logic          wrap_q, wrap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpn_q, dpn_d;
    logic          frame_q, frame_d;

    logic [3:0]    cur_dig;
    logic          cur_blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q     <= '0;
            idx_q     <= '0;
            shd_dig_q <= '0;
            shd_dp_q  <= '0;
            wrap_q    <= 1'b0;
            an_q      <= '1;
            seg_q     <= '1;
            dpn_q     <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            shd_dig_q <= shd_dig_d;
            shd_dp_q  <= shd_dp_d;
            wrap_q    <= wrap_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dpn_q     <= dpn_d;
            frame_q   <= frame_d;
        end
    end

    // Next-state: prescaler, digit index and shadow capture
    always_comb begin
        pre_d     = pre_q;
        idx_d     = idx_q;
        wrap_d    = 1'b0;
        shd_dig_d = load ? digits : shd_dig_q;
        shd_dp_d  = load ? dp : shd_dp_q;
        if (en) begin
            if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                idx_d  = idx_q + 2'd1;
                wrap_d = (idx_q == 2'd3);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    assign cur_dig = shd_dig_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
    logic [3:0] blank_vec;

    // A digit is blanked only while every more-significant digit is blank too
    always_comb begin
        blank_vec    = '0;
        blank_vec[3] = (shd_dig_q[15:12] == 4'h0);
        blank_vec[2] = blank_vec[3] && (shd_dig_q[11:8] == 4'h0);
        blank_vec[1] = blank_vec[2] && (shd_dig_q[7:4] == 4'h0);
    end

    assign cur_blank = blank_vec[idx_q];
`else
    assign cur_blank = 1'b0;
`endif

    // Outputs are registered from the pre-edge scan state, so they lag by one
    // cycle; frame is delayed through wrap_q to line up with idx 0 on the pins.
    always_comb begin
        an_d = '1;
        if (en && (pre_q >= PRE_LIT)) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d   = cur_blank ? 7'b1111111 : hex7(cur_dig);
        dpn_d   = ~shd_dp_q[idx_q];
        frame_d = wrap_q;
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp_n  = dpn_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed testbench for seg7_scan with SCAN_DIV=4, DEAD_CYC=1.
// Every applied cycle is one vector: inputs are driven, one rising edge is
// taken, and an/seg/dp_n/frame are compared 1 time unit later.
module tb_seg7_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame;

    int unsigned nvec;
    int unsigned nmis;

    // Segment codes {g..a}, active low
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S7 = 7'h78, S8 = 7'h00;
    localparam logic [6:0] S9 = 7'h10, SA = 7'h08, SB = 7'h03, SC = 7'h46;
    localparam logic [6:0] SD = 7'h21, SE = 7'h06, SF = 7'h0E, OFF = 7'h7F;
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] ZB = OFF;
`else
    localparam logic [6:0] ZB = S0;
`endif

    typedef struct {
        logic        r;
        logic        e;
        logic        l;
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpn;
        logic        fr;
    } vec_t;

    vec_t tbl[$];

    seg7_scan #(
        .SCAN_DIV(4),
        .DEAD_CYC(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .digits (digits),
        .dp     (dp),
        .an     (an),
        .seg    (seg),
        .dp_n   (dp_n),
        .frame  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input logic r, input logic e, input logic l,
                         input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp, input logic efr, input string name);
        rst    = r;
        en     = e;
        load   = l;
        digits = d;
        dp     = p;
        @(posedge clk);
        #1;
        nvec++;
        if (an !== ean || seg !== eseg || dp_n !== edp || frame !== efr) begin
            nmis++;
            $display("FAIL %s (vec %0d): got an=%b seg=%b dp_n=%b frame=%b, want an=%b seg=%b dp_n=%b frame=%b",
                     name, nvec, an, seg, dp_n, frame, ean, eseg, edp, efr);
        end
    endtask

    // One full slot starting at pre=0: dead cycle, then three lit cycles.
    // The optional load lands on the last edge, i.e. the slot change.
    task automatic slot_check(input logic [1:0] i, input logic [6:0] eseg,
                              input logic edp, input logic efr, input logic ld,
                              input logic [15:0] ld_d, input logic [3:0] ld_p);
        logic [3:0] lit;
        string      nm;
        lit    = 4'hF;
        lit[i] = 1'b0;
        nm     = $sformatf("slot%0d", i);
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF, eseg, edp, efr, {nm, "_dead"});
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, lit, eseg, edp, 1'b0, {nm, "_lit"});
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, lit, eseg, edp, 1'b0, {nm, "_lit"});
        cycle(1'b1, 1'b1, ld, ld_d, ld_p, lit, eseg, edp, 1'b0, {nm, "_last"});
    endtask

    initial begin
        nvec   = 0;
        nmis   = 0;
        rst    = 1'b0;
        en     = 1'b1;
        load   = 1'b1;
        digits = 16'h1234;
        dp     = 4'b0100;

        // r  e  l  digits    dp       an     seg  dpn fr
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100, 4'hF, OFF, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100, 4'hF, OFF, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100, 4'hF, OFF, 1'b1, 1'b0});
        // released, scan disabled: shadow must still be zero
        tbl.push_back('{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'hF, S0,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 16'h1234, 4'b0100, 4'hF, S0,  1'b1, 1'b0});
        // slot 0 (digit 4)
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF, S4,  1'b1, 1'b0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hE, S4, 1'b1, 1'b0});
        // slot 1 (digit 3)
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF, S3,  1'b1, 1'b0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hD, S3, 1'b1, 1'b0});
        // slot 2 (digit 2, decimal point on)
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF, S2,  1'b0, 1'b0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hB, S2, 1'b0, 1'b0});
        // slot 3 (digit 1)
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF, S1,  1'b1, 1'b0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'h7, S1, 1'b1, 1'b0});
        // wrap back to slot 0: frame pulse on its first cycle
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF, S4,  1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hE, S4,  1'b1, 1'b0});
        // load ABCD at pre=2 of slot 0: visible on the very next lit cycle
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'hABCD, 4'b0000, 4'hE, S4,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'hE, SD,  1'b1, 1'b0});

        foreach (tbl[k])
            cycle(tbl[k].r, tbl[k].e, tbl[k].l, tbl[k].d, tbl[k].p,
                  tbl[k].an, tbl[k].seg, tbl[k].dpn, tbl[k].fr, $sformatf("table%0d", k));

        // Hex decode of ABCD, then EF89 loaded exactly at the 0->1 slot change
        slot_check(2'd1, SC, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd2, SB, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd3, SA, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd0, SD, 1'b1, 1'b1, 1'b1, 16'hEF89, 4'b0001);
        slot_check(2'd1, S8, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd2, SF, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd3, SE, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd0, S9, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Enable freeze at pre=2 of slot 1
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF, S8, 1'b1, 1'b0, "frz_pre0");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hD, S8, 1'b1, 1'b0, "frz_pre1");
        for (int k = 0; k < 5; k++)
            cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'hF, S8, 1'b1, 1'b0, "frz_off");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hD, S8, 1'b1, 1'b0, "frz_resume2");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hD, S8, 1'b1, 1'b0, "frz_resume3");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF, SF, 1'b1, 1'b0, "frz_next_dead");

        // Load 0007 at the end of slot 2: slot 2 keeps F, slot 3 gets 0, slot 0 gets 7
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hB, SF, 1'b1, 1'b0, "mid_s2");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hB, SF, 1'b1, 1'b0, "mid_s2");
        cycle(1'b1, 1'b1, 1'b1, 16'h0007, 4'h0, 4'hB, SF, 1'b1, 1'b0, "mid_s2_load");
        slot_check(2'd3, ZB, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd0, S7, 1'b1, 1'b1, 1'b1, 16'h0050, 4'h0);

        // Leading zeros: 0050 blanks digits 3,2; 0003 blanks digits 3,2,1
        slot_check(2'd1, S5, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd2, ZB, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd3, ZB, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd0, S0, 1'b1, 1'b1, 1'b1, 16'h0003, 4'h0);
        slot_check(2'd1, ZB, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd2, ZB, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd3, ZB, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        slot_check(2'd0, S3, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);

        // Reset mid-slot overrides a coincident load
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF, ZB, 1'b1, 1'b0, "pre_rst");
        cycle(1'b0, 1'b1, 1'b1, 16'h8888, 4'hF, 4'hF, OFF, 1'b1, 1'b0, "rst_mid");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF, S0, 1'b1, 1'b0, "post_rst_dead");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hE, S0, 1'b1, 1'b0, "post_rst_first_an");
        cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'hE, S0, 1'b1, 1'b0, "post_rst_lit");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display driver that sits directly downstream of the `count_6` / mod-N counter chain in the timekeeping design. It captures the BCD/hex digit values produced by the counters into a shadow register on a load strobe. It scans the four digits round-robin with a programmable dwell time and anti-ghosting dead time. It drives active-low anode and segment lines to the board display.

## Interface
- `SCAN_DIV`, 50000, clock cycles per digit slot; must be ≥ 2.
- `DEAD_CYC`, 1000, cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `clk` input 1: single clock; all state on its rising edge.
- `rst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `en` input 1: scan enable; low freezes prescaler and digit index and blanks all anodes.
- `load` input 1: one-cycle strobe; captures `digits` and `dp` into the shadow register.
- `digits` input 16: four 4-bit values, [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- `dp` input 4: decimal point request per digit, bit i = digit i.
- `an` output 4: active-low anode select, bit i = digit i.
- `seg` output 7: active-low segments, bit order {g,f,e,d,c,b,a}.
- `dp_n` output 1: active-low decimal point.
- `frame` output 1: one-cycle pulse when the digit index wraps 3→0.

## Operation
- Reset (`rst`=0 at an edge): prescaler `pre`=0, digit index `idx`=0, shadow digits=0, shadow dp=0. Outputs `an`=4'b1111, `seg`=7'b1111111, `dp_n`=1, `frame`=0.
- Shadow: on `load`=1, the shadow takes `digits`/`dp` at that edge, independent of `en`. The display only ever reads the shadow. A `load` coincident with a slot change is used by the new slot.
- Prescaler: when `en`=1, `pre` counts 0…`SCAN_DIV`-1. At `SCAN_DIV`-1, `pre`→0 and `idx`→`idx`+1 mod 4. The 3→0 wrap pulses `frame`.
- Slot output: while `en`=1 and `pre` ≥ `DEAD_CYC`, bit `idx` of `an` is 0 and all other bits are 1. Otherwise `an`=4'b1111.
- Decode is hex, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- `dp_n` = ~shadow dp[`idx`].
- `en` low mid-slot: `pre` and `idx` hold and `an`=1111. Scanning resumes from the held values when `en` returns high.
- Reset mid-slot overrides `en`/`load` at the same edge.

## Timing
- All outputs are registered. `an`/`seg`/`dp_n` reflect the `pre`/`idx`/shadow values present before the edge, so they lag one cycle.
- Load-to-display latency: a new value first appears on the next cycle in which its slot is active.
- The first `an` assertion after reset occurs `DEAD_CYC`+1 edges after `rst` deasserts, with `en`=1.
- `frame` is high for exactly one cycle per 4×`SCAN_DIV` enabled cycles. It is asserted on the same cycle in which `idx`=0 first appears on the outputs.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digit 3 is blanked if its shadow value = 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3..1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives `seg`=1111111; `an` timing and `dp_n` are unchanged.
- Not defined: every digit is always decoded. The blanking logic must be absent from the netlist.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `en`=1, `load`=1 → `an`=1111, `seg`=1111111, `dp_n`=1, `frame`=0 throughout. Shadow reads 0 after release.
- Scan order (`SCAN_DIV`=4, `DEAD_CYC`=1): load `digits`=16'h1234, `dp`=4'b0100.
  - `an` sequence per slot: 1111 for 1 cycle, then 3 cycles of 1110/1101/1011/0111 for slots 0…3.
  - `seg` per slot = codes of 4/3/2/1.
  - `dp_n`=0 only during slot 2.
  - `frame` pulses every 16 cycles.
- Hex decode: load 16'hABCD, then 16'hEF89 → each slot shows the listed codes for A–F, 8, 9.
- Enable freeze: drop `en` at `pre`=2 of slot 1 for 5 cycles → `an`=1111 during the freeze. Slot 1 then resumes at `pre`=2 with 2 remaining lit cycles.
- Load mid-frame: load 16'h0007 during slot 2 → slot 2 keeps its old value. Slot 3 shows 0 (blank with `SEG7_LZ_BLANK_EN`), slot 0 shows 7.
- Blanking (macro defined): load 16'h0050 → digits 3 and 2 are blanked, digit 1 shows 5, digit 0 shows 0. Without the macro, all four digits are decoded.
